seq_alu: RTL

- Multi-cycle ALU. It is the consumer end of the ALU-control interface: it takes the 5-bit control code and sign flag produced by the decode stage and executes the operation.
- Shifts run in an iterative 1-bit-per-cycle shifter. All other operations complete in one cycle.
- Handshakes are valid/ready on both sides. It sits between decode/operand select and writeback in the multi-cycle processor variant.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_shifter.sv | 50 +++++
 rtl/seq_alu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, FSM states, default widths.
package alu_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd6;
  localparam logic [4:0] ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;
  localparam logic [4:0] ALU_LUI = 5'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Codes that go through the iterative shifter (lui does not).
  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/seq_shifter.sv
// Iterative 1-bit-per-cycle shifter: working register plus down-counter.
module seq_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data,
  output logic               done_c,
  output logic [WIDTH-1:0]   shifted_c
);

  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               arith_q;

  // dir=1 shifts right; arith selects sign fill for right shifts.
  always_comb begin
    shifted_c = {work_q[WIDTH-2:0], 1'b0};
    if (dir_q) begin
      shifted_c = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end
    done_c = (cnt_q == SHAMT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      work_q  <= data;
      cnt_q   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      work_q <= shifted_c;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Optional signed-overflow output enabled by defining SEQ_ALU_OVF_EN.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_ctrl,
  input  logic             sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef SEQ_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_e             state_q, state_nx;
  logic [WIDTH-1:0]   result_nx;
  logic [WIDTH-1:0]   op_res_c;
  logic [WIDTH-1:0]   sum_c, diff_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic               sh_start_c;
  logic               sh_done_c;
  logic [WIDTH-1:0]   sh_shifted_c;

  assign shamt_c = in1[SHAMT_W-1:0];
  assign sum_c   = in1 + in2;
  assign diff_c  = in1 - in2;

  // Single-cycle datapath; shifts land here only when shamt is zero.
  always_comb begin
    op_res_c = '0;
    unique case (alu_ctrl)
      ALU_ADD: op_res_c = sum_c;
      ALU_SUB: op_res_c = diff_c;
      ALU_AND: op_res_c = in1 & in2;
      ALU_OR:  op_res_c = in1 | in2;
      ALU_XOR: op_res_c = in1 ^ in2;
      ALU_NOR: op_res_c = ~(in1 | in2);
      ALU_SLL, ALU_SRL, ALU_SRA: op_res_c = in2;
      ALU_SLT: begin
        if (sign) op_res_c = WIDTH'($signed(in1) < $signed(in2));
        else      op_res_c = WIDTH'(in1 < in2);
      end
      ALU_LUI: op_res_c = in2 << 16;
      default: op_res_c = '0;
    endcase
  end

  seq_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (sh_start_c),
    .dir      (alu_ctrl != ALU_SLL),
    .arith    (alu_ctrl == ALU_SRA),
    .shamt    (shamt_c),
    .data     (in2),
    .done_c   (sh_done_c),
    .shifted_c(sh_shifted_c)
  );

`ifdef SEQ_ALU_OVF_EN
  logic ovf_c, ovf_nx;

  always_comb begin
    ovf_c = 1'b0;
    if (sign && (alu_ctrl == ALU_ADD)) begin
      ovf_c = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_c[WIDTH-1] != in1[WIDTH-1]);
    end else if (sign && (alu_ctrl == ALU_SUB)) begin
      ovf_c = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_c[WIDTH-1] != in1[WIDTH-1]);
    end
  end
`endif

  // Next-state and next-result selection.
  always_comb begin
    state_nx   = state_q;
    result_nx  = result;
    sh_start_c = 1'b0;
`ifdef SEQ_ALU_OVF_EN
    ovf_nx     = overflow;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_shift(alu_ctrl) && (shamt_c != '0)) begin
            sh_start_c = 1'b1;
            state_nx   = SHIFT;
          end else begin
            result_nx = op_res_c;
            state_nx  = DONE;
`ifdef SEQ_ALU_OVF_EN
            ovf_nx    = ovf_c;
`endif
          end
        end
      end
      SHIFT: begin
        if (sh_done_c) begin
          result_nx = sh_shifted_c;
          state_nx  = DONE;
`ifdef SEQ_ALU_OVF_EN
          ovf_nx    = 1'b0;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result    <= '0;
      zero      <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      state_q   <= state_nx;
      result    <= result_nx;
      zero      <= (result_nx == '0);
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
`ifdef SEQ_ALU_OVF_EN
      overflow  <= ovf_nx;
`endif
    end
  end

endmodule
